// File: rtl/token_session_arbiter_if.sv
// token_session_arbiter_if: request, authentication and session bundle between users and the arbiter.
interface token_session_arbiter_if #(
  parameter int NUM_USERS = 4,
  parameter int TOKEN_W = 3,
  parameter int DATA_W = 8
);
  logic [TOKEN_W-1:0] system_token, user_token;
  logic [NUM_USERS-1:0] request, grant, lockout;
  logic confirm, busy, auth_ok, session_done;
  logic [DATA_W-1:0] TimeData, data_P, data_Q;
  modport slave (
    input system_token, request, confirm, user_token, TimeData,
    output grant, busy, auth_ok, lockout, data_P, data_Q, session_done
  );
  modport master (
    output system_token, request, confirm, user_token, TimeData,
    input grant, busy, auth_ok, lockout, data_P, data_Q, session_done
  );
endinterface

// File: rtl/token_session_arbiter.sv
// token_session_arbiter: round-robin arbiter granting a token-authenticated, timed session to one user at a time.
module token_session_arbiter #(
  parameter int NUM_USERS = 4,
  parameter int TOKEN_W = 3,
  parameter int DATA_W = 8,
  parameter int AUTH_TIMEOUT = 8,
  parameter int MAX_FAILS = 3
) (
  input logic clock,
  input logic reset,
  token_session_arbiter_if.slave bus
);
  localparam int UW = $clog2(NUM_USERS);
  localparam int TW = $clog2(AUTH_TIMEOUT);
  localparam int FW = $clog2(MAX_FAILS + 1);
  typedef enum logic [2:0] {IDLE, AUTH, LOAD, RUN, RELEASE} state_t;
  state_t state_q;
  logic [UW-1:0] last_q, g_q, win_d;
  logic [TW-1:0] timer_q;
  logic [FW-1:0] fail_q [NUM_USERS];
  logic [NUM_USERS-1:0] grant_q, lockout_q, elig;
  logic [DATA_W-1:0] data_p_q, data_q_q;
  logic busy_q, auth_ok_q, done_q, win_vld_d, rel_d, done_d;
  logic req_g, tok_ok, tmo, zero_td;
  assign elig = bus.request & ~lockout_q;
  assign req_g = bus.request[g_q];
  assign tok_ok = bus.user_token == bus.system_token;
  assign tmo = timer_q == TW'(AUTH_TIMEOUT - 1);
  assign zero_td = bus.TimeData == '0;
  // Scan farthest-to-nearest from last_q so the nearest eligible user wins.
  always_comb begin
    win_vld_d = 1'b0;
    win_d = '0;
    for (int k = NUM_USERS; k >= 1; k--) begin
      if (elig[UW'((int'(last_q) + k) % NUM_USERS)]) begin
        win_vld_d = 1'b1;
        win_d = UW'((int'(last_q) + k) % NUM_USERS);
      end
    end
  end
  assign rel_d = (state_q == AUTH) ? (!req_g || (bus.confirm ? !tok_ok : tmo)) :
                 (state_q == LOAD) ? (!req_g || (bus.confirm ? zero_td : tmo)) :
                 (state_q == RUN)  ? (!req_g || data_q_q <= DATA_W'(1)) : 1'b0;
  assign done_d = (state_q == RUN) ? rel_d : (state_q == LOAD && req_g && bus.confirm && zero_td);
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q <= UW'(NUM_USERS - 1);
      g_q <= '0;
      timer_q <= '0;
      for (int i = 0; i < NUM_USERS; i++) fail_q[i] <= '0;
      grant_q <= '0;
      lockout_q <= '0;
      busy_q <= 1'b0;
      auth_ok_q <= 1'b0;
      done_q <= 1'b0;
      data_p_q <= '0;
      data_q_q <= '0;
    end else begin
      done_q <= done_d;
      timer_q <= timer_q + 1'b1;
      if (rel_d) begin
        state_q <= RELEASE;
        grant_q <= '0;
        auth_ok_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (win_vld_d) begin
          state_q <= AUTH;
          g_q <= win_d;
          grant_q <= NUM_USERS'(1) << win_d;
          busy_q <= 1'b1;
          timer_q <= '0;
        end
        AUTH: if (req_g && bus.confirm) begin
          if (tok_ok) begin
            fail_q[g_q] <= '0;
            state_q <= LOAD;
            auth_ok_q <= 1'b1;
            timer_q <= '0;
          end else begin
            if (fail_q[g_q] != FW'(MAX_FAILS)) fail_q[g_q] <= fail_q[g_q] + 1'b1;
            if (fail_q[g_q] == FW'(MAX_FAILS - 1)) lockout_q[g_q] <= 1'b1;
          end
        end
        LOAD: if (req_g && bus.confirm) begin
          data_p_q <= bus.TimeData;
          data_q_q <= bus.TimeData;
          if (!zero_td) state_q <= RUN;
        end
        RUN: if (req_g && data_q_q != '0) data_q_q <= data_q_q - 1'b1;
        RELEASE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          last_q <= g_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.grant = grant_q;
  assign bus.busy = busy_q;
  assign bus.auth_ok = auth_ok_q;
  assign bus.lockout = lockout_q;
  assign bus.data_P = data_p_q;
  assign bus.data_Q = data_q_q;
  assign bus.session_done = done_q;
endmodule

// File: tb/tb_token_session_arbiter.sv
// tb_token_session_arbiter: directed and randomized sessions checked against a transaction-level model.
module tb_token_session_arbiter;
  localparam int N = 4, TKW = 3, DW = 8, TO = 8, MF = 3;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  token_session_arbiter_if #(.NUM_USERS(N), .TOKEN_W(TKW), .DATA_W(DW)) bus();
  token_session_arbiter #(.NUM_USERS(N), .TOKEN_W(TKW), .DATA_W(DW), .AUTH_TIMEOUT(TO), .MAX_FAILS(MF)) dut (
    .clock(clk),
    .reset(rst_n),
    .bus(bus)
  );
  int errors = 0, checks = 0;
  int last;
  int fails [N];
  logic [N-1:0] lock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    last = N - 1;
    foreach (fails[i]) fails[i] = 0;
    lock = '0;
  endtask
  function automatic int pick(input logic [N-1:0] el);
    for (int k = 1; k <= N; k++) if (el[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction
  task automatic chk_zero(input string tag);
    chk({tag, "_grant"}, bus.grant, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_auth_ok"}, bus.auth_ok, 0);
    chk({tag, "_lockout"}, bus.lockout, 0);
    chk({tag, "_data_P"}, bus.data_P, 0);
    chk({tag, "_data_Q"}, bus.data_Q, 0);
    chk({tag, "_done"}, bus.session_done, 0);
  endtask
  task automatic apply_reset();
    rst_n = 1'b0;
    bus.request = '0;
    bus.confirm = 1'b0;
    tick();
    chk_zero("rst");
    rst_n = 1'b1;
    model_reset();
  endtask
  task automatic finish_release(input int w, input logic exp_done);
    chk("rel_grant", bus.grant, 0);
    chk("rel_busy", bus.busy, 1);
    chk("rel_auth_ok", bus.auth_ok, 0);
    chk("rel_lockout", bus.lockout, lock);
    chk("rel_done", bus.session_done, exp_done);
    bus.confirm = 1'b0;
    tick();
    chk("idle_busy", bus.busy, 0);
    chk("idle_done", bus.session_done, 0);
    last = w;
  endtask
  // act: 0 drop in AUTH, 1 wrong token, 2 AUTH timeout, 3 good token (td<0 means LOAD timeout)
  task automatic trial(input logic [N-1:0] mask, input int act, input int wait_c, input int td, input int drop_at);
    int w, stop;
    logic [TKW-1:0] bad;
    bus.request = mask;
    bus.confirm = 1'b0;
    w = pick(mask & ~lock);
    tick();
    if (w < 0) begin
      chk("nogrant_grant", bus.grant, 0);
      chk("nogrant_busy", bus.busy, 0);
      return;
    end
    chk("grant", bus.grant, 1 << w);
    chk("auth_busy", bus.busy, 1);
    chk("auth_auth_ok", bus.auth_ok, 0);
    repeat (wait_c) tick();
    if (act == 0) begin
      bus.request[w] = 1'b0;
      tick();
      finish_release(w, 1'b0);
    end else if (act == 1) begin
      bad = TKW'($urandom_range(1, 7));
      bus.user_token = bus.system_token ^ bad;
      bus.confirm = 1'b1;
      if (fails[w] < MF) fails[w]++;
      if (fails[w] == MF) lock[w] = 1'b1;
      tick();
      finish_release(w, 1'b0);
    end else if (act == 2) begin
      repeat (TO - 1 - wait_c) tick();
      chk("tmo_grant_held", bus.grant, 1 << w);
      tick();
      finish_release(w, 1'b0);
    end else begin
      bus.user_token = bus.system_token;
      bus.confirm = 1'b1;
      fails[w] = 0;
      tick();
      bus.confirm = 1'b0;
      chk("load_auth_ok", bus.auth_ok, 1);
      chk("load_grant", bus.grant, 1 << w);
      if (td < 0) begin
        repeat (TO - 1) tick();
        chk("load_tmo_auth_ok", bus.auth_ok, 1);
        tick();
        finish_release(w, 1'b0);
        return;
      end
      repeat (wait_c) tick();
      bus.TimeData = DW'(td);
      bus.confirm = 1'b1;
      tick();
      bus.confirm = 1'b0;
      chk("data_P", bus.data_P, td);
      chk("data_Q_load", bus.data_Q, td);
      if (td == 0) begin
        finish_release(w, 1'b1);
        return;
      end
      chk("run_auth_ok", bus.auth_ok, 1);
      chk("run_done", bus.session_done, 0);
      stop = (drop_at >= 0 && drop_at < td) ? drop_at : td - 1;
      for (int j = 1; j <= stop; j++) begin
        tick();
        chk("run_data_Q", bus.data_Q, td - j);
        chk("run_done_low", bus.session_done, 0);
      end
      if (stop != td - 1 || (drop_at >= 0 && drop_at < td)) bus.request[w] = 1'b0;
      tick();
      chk("end_data_Q", bus.data_Q, (drop_at >= 0 && drop_at < td) ? td - stop : 0);
      chk("end_data_P", bus.data_P, td);
      finish_release(w, 1'b1);
    end
  endtask
  initial begin
    int w, r, td;
    bus.system_token = 3'b101;
    bus.user_token = '0;
    bus.TimeData = '0;
    bus.request = '0;
    bus.confirm = 1'b0;
    model_reset();
    tick();
    apply_reset();
    trial(4'b0001, 3, 0, 8'hF2, -1);
    repeat (3) trial(4'b0010, 1, 0, 0, -1);
    chk("lockout_user1", bus.lockout, 4'b0010);
    trial(4'b0010, 3, 0, 4, -1);
    w = pick(4'b0001 & ~lock);
    bus.request = 4'b0001;
    tick();
    chk("rr_grant", bus.grant, 1 << w);
    bus.user_token = bus.system_token;
    bus.confirm = 1'b1;
    tick();
    bus.TimeData = 8'h80;
    tick();
    bus.confirm = 1'b0;
    repeat (64) tick();
    chk("mid_run_data_Q", bus.data_Q, 8'h40);
    rst_n = 1'b0;
    tick();
    chk_zero("run_rst");
    rst_n = 1'b1;
    bus.request = '0;
    model_reset();
    trial(4'b0010, 3, 0, 3, -1);
    apply_reset();
    repeat (5) trial(4'b1111, 3, 0, 2, -1);
    trial(4'b0100, 2, 0, 0, -1);
    chk("tmo_no_lockout", bus.lockout, 0);
    trial(4'b0100, 3, 1, 5, -1);
    trial(4'b1000, 3, 0, 0, -1);
    for (int i = 0; i < 250; i++) begin
      if (i % 40 == 39) apply_reset();
      bus.system_token = TKW'($urandom);
      r = $urandom_range(0, 7);
      td = (r == 0) ? 0 : (r == 1) ? -1 : $urandom_range(1, 12);
      trial(N'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), td,
            ($urandom_range(0, 1) == 1) ? $urandom_range(0, 12) : -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
